intr_ctrl: RTL and testbench

- Interrupt controller sitting directly upstream of the CPU control/sequencing stage.
- Collects external request lines and latches edge-triggered requests.
- Applies a per-source mask and the global interrupt enable (IEN), then drives the single `irq` input that the sequencer samples at instruction fetch.
- Consumes the sequencer's `set_ien`/`clear_ien` strobes and exposes a small 4-register bus window so ISRs can read the cause and acknowledge it.

---
 rtl/intr_ctrl.sv | 122 ++++++++++++
 tb/tb_intr_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge/level source capture, per-source mask, global enable, registered irq.
// Optional macro INTR_SYNC_EN adds a 2-flop synchronizer on every src line.
module intr_ctrl #(
  parameter int NUM_SRC = 4,
  parameter logic [NUM_SRC-1:0] EDGE_SRC = NUM_SRC'(4'b0011)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  input  logic               set_ien,
  input  logic               clear_ien,
  input  logic [1:0]         reg_sel,
  input  logic               reg_wr,
  input  logic [15:0]        reg_wdata,
  output logic [15:0]        reg_rdata,
  output logic               irq,
  output logic               ien
);

  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_q_reg;
  logic               primed_reg;
  logic [NUM_SRC-1:0] pend_reg, pend_next;
  logic [NUM_SRC-1:0] mask_reg, mask_next;
  logic               ien_reg, ien_next;
  logic               irq_reg;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] active;
  logic [3:0]         cause_idx;
  logic               wr_pend, wr_mask, wr_status;
  logic               unused_wdata;

`ifdef INTR_SYNC_EN
  logic [NUM_SRC-1:0] sync1_reg, sync2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= src;
      sync2_reg <= sync1_reg;
    end
  end

  assign src_s = sync2_reg;
`else
  assign src_s = src;
`endif

  assign wr_pend   = reg_wr && (reg_sel == 2'd0);
  assign wr_mask   = reg_wr && (reg_sel == 2'd1);
  assign wr_status = reg_wr && (reg_sel == 2'd3);

  // primed masks the first post-reset cycle so a line already high is not seen as an edge
  assign rise = src_s & ~src_q_reg & {NUM_SRC{primed_reg}};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
      if (EDGE_SRC[gi]) begin : g_edge
        assign pend_next[gi] = rise[gi] | (pend_reg[gi] & ~(wr_pend & reg_wdata[gi]));
      end else begin : g_level
        assign pend_next[gi] = src_s[gi];
      end
    end
  endgenerate

  assign mask_next = wr_mask ? reg_wdata[NUM_SRC-1:0] : mask_reg;

  always_comb begin
    ien_next = ien_reg;
    if (clear_ien)      ien_next = 1'b0;
    else if (set_ien)   ien_next = 1'b1;
    else if (wr_status) ien_next = reg_wdata[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q_reg  <= '0;
      primed_reg <= 1'b0;
      pend_reg   <= '0;
      mask_reg   <= '0;
      ien_reg    <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      src_q_reg  <= src_s;
      primed_reg <= 1'b1;
      pend_reg   <= pend_next;
      mask_reg   <= mask_next;
      ien_reg    <= ien_next;
      irq_reg    <= ien_next & (|(pend_next & mask_next));
    end
  end

  assign active = pend_reg & mask_reg;

  // Scan high to low so the lowest-numbered active source wins
  always_comb begin
    cause_idx = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) cause_idx = 4'(i);
    end
  end

  always_comb begin
    reg_rdata = 16'h0000;
    case (reg_sel)
      2'd0: reg_rdata = 16'(pend_reg);
      2'd1: reg_rdata = 16'(mask_reg);
      2'd2: reg_rdata = {|active, 11'd0, cause_idx};
      2'd3: reg_rdata = {15'd0, ien_reg};
      default: reg_rdata = 16'h0000;
    endcase
  end

  assign unused_wdata = ^reg_wdata[15:NUM_SRC];

  assign irq = irq_reg;
  assign ien = ien_reg;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: directed scenarios plus random traffic against a rule-level model.
module tb_intr_ctrl;

  localparam int N = 4;
  localparam logic [3:0] EDGE = 4'b0011;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src;
  logic        set_ien, clear_ien;
  logic [1:0]  reg_sel;
  logic        reg_wr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        irq, ien;

  intr_ctrl dut (
    .clk(clk), .rst(rst), .src(src), .set_ien(set_ien), .clear_ien(clear_ien),
    .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .irq(irq), .ien(ien)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        irq;
    logic        ien;
    logic [15:0] rdata;
    logic [1:0]  sel;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference state, in terms of the observable rules
  bit [3:0] m_pend, m_mask, m_prev, m_s1, m_s2;
  bit       m_ien, m_irq, m_primed;

  function automatic logic [15:0] model_read(input logic [1:0] sel);
    logic [15:0] r;
    bit [3:0] act;
    r = 16'h0;
    act = m_pend & m_mask;
    case (sel)
      2'd0: r = {12'd0, m_pend};
      2'd1: r = {12'd0, m_mask};
      2'd2: begin
        for (int i = 0; i < N; i++) begin
          if (act[i]) begin
            r = 16'h8000 | 16'(i);
            break;
          end
        end
      end
      default: r = {15'd0, m_ien};
    endcase
    return r;
  endfunction

  task automatic cyc(input bit r, input bit [3:0] s, input bit st, input bit cl,
                     input bit [1:0] sel, input bit wr, input bit [15:0] wd);
    exp_t e;
    bit [3:0] seen, np, nm;
    bit nien;
    @(negedge clk);
    e.irq = m_irq; e.ien = m_ien; e.sel = sel; e.rdata = model_read(sel);
    exp_q.push_back(e);
    rst = r; src = s; set_ien = st; clear_ien = cl;
    reg_sel = sel; reg_wr = wr; reg_wdata = wd;
    if (r) begin
      m_pend = 0; m_mask = 0; m_ien = 0; m_irq = 0;
      m_prev = 0; m_primed = 0; m_s1 = 0; m_s2 = 0;
    end else begin
`ifdef INTR_SYNC_EN
      seen = m_s2; m_s2 = m_s1; m_s1 = s;
`else
      seen = s;
`endif
      for (int i = 0; i < N; i++) begin
        if (EDGE[i]) begin
          if (m_primed && seen[i] && !m_prev[i]) np[i] = 1'b1;
          else if (wr && sel == 2'd0 && wd[i]) np[i] = 1'b0;
          else np[i] = m_pend[i];
        end else begin
          np[i] = seen[i];
        end
      end
      nm = (wr && sel == 2'd1) ? wd[3:0] : m_mask;
      if (cl) nien = 1'b0;
      else if (st) nien = 1'b1;
      else if (wr && sel == 2'd3) nien = wd[0];
      else nien = m_ien;
      m_irq = nien && ((np & nm) != 0);
      m_pend = np; m_mask = nm; m_ien = nien;
      m_prev = seen; m_primed = 1'b1;
    end
  endtask

  // Monitor: one comparison line of state per cycle, decoupled from stimulus
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (irq !== e.irq || ien !== e.ien || reg_rdata !== e.rdata) begin
          miscompares++;
          $display("FAIL vec%0d sel=%0d: irq=%b ien=%b rdata=%h, required irq=%b ien=%b rdata=%h",
                   vectors, e.sel, irq, ien, reg_rdata, e.irq, e.ien, e.rdata);
        end else begin
          $display("vec%0d sel=%0d irq=%b ien=%b rdata=%h ok", vectors, e.sel, irq, ien, reg_rdata);
        end
      end
    end
  end

  initial begin
    int drain;
    rst = 1'b1; src = 4'b0001; set_ien = 0; clear_ien = 0;
    reg_sel = 0; reg_wr = 0; reg_wdata = 0;
    // reset with src[0] held high, then idle and read every register
    repeat (3) cyc(1, 4'b0001, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 4'b0001, 0, 0, 2'(i), 0, 0);
    // edge path
    cyc(0, 4'b0000, 0, 0, 1, 1, 16'h0003);
    cyc(0, 4'b0000, 0, 0, 3, 1, 16'h0001);
    cyc(0, 4'b0001, 0, 0, 0, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0);
    cyc(0, 4'b0000, 0, 0, 2, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0, 1, 16'h0001);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0);
    cyc(0, 4'b0000, 0, 0, 2, 0, 0);
    // priority and level
    cyc(0, 4'b1100, 0, 0, 1, 1, 16'h000F);
    repeat (2) cyc(0, 4'b1100, 0, 0, 2, 0, 0);
    repeat (2) cyc(0, 4'b1000, 0, 0, 2, 0, 0);
    repeat (3) cyc(0, 4'b0000, 0, 0, 2, 0, 0);
    // ien strobes with a pending level source
    cyc(0, 4'b1000, 0, 0, 3, 1, 16'h0000);
    repeat (2) cyc(0, 4'b1000, 0, 0, 3, 0, 0);
    cyc(0, 4'b1000, 1, 0, 3, 0, 0);
    cyc(0, 4'b1000, 0, 0, 3, 0, 0);
    cyc(0, 4'b1000, 0, 1, 3, 0, 0);
    cyc(0, 4'b1000, 1, 0, 3, 0, 0);
    cyc(0, 4'b1000, 1, 1, 3, 0, 0);
    cyc(0, 4'b0000, 0, 0, 3, 0, 0);
    // W1C race on edge source 1, then a plain W1C
    cyc(0, 4'b0010, 0, 0, 0, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0);
    cyc(0, 4'b0010, 0, 0, 0, 1, 16'h0002);
    cyc(0, 4'b0010, 0, 0, 0, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0, 1, 16'h0002);
    cyc(0, 4'b0000, 0, 0, 0, 0, 0);
    // mid-operation reset discards everything
    cyc(0, 4'b0011, 1, 0, 1, 1, 16'h000F);
    cyc(1, 4'b0011, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 4'b0011, 0, 0, 0, 0, 0);
    // random traffic
    for (int k = 0; k < 2000; k++) begin
      bit [3:0] s;
      s = src;
      if ($urandom_range(0, 3) == 0) s = 4'($urandom);
      cyc(($urandom_range(0, 199) == 0), s,
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
          2'($urandom), ($urandom_range(0, 3) == 0), 16'($urandom));
    end
    drain = 0;
    while (exp_q.size() != 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
